// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like master port between instruction fetch
// and the data (load/store) requester. One outstanding transaction at a time;
// data has priority, but fetch is forced after MAX_DATA_RUN consecutive data
// grants taken while a fetch was waiting.
module sram_req_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  // instruction fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  // data side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  // master port
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  state_t              state_q;
  logic                owner_q;   // 0 = inst, 1 = data
  logic [RUN_W-1:0]    run_q;
  logic [RUN_W-1:0]    run_d;
  logic                grant_data_d;
  logic                grant_inst_d;
  logic                m_req_q;
  logic                m_wr_q;
  logic [1:0]          m_size_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [31:0]         m_wdata_q;
  logic                addr_hs;
  logic                data_hs;

  // Arbitration decision and next run count, consulted only while IDLE.
  always_comb begin
    grant_data_d = data_req && (!inst_req || (run_q < RUN_MAX));
    grant_inst_d = !grant_data_d && inst_req;
    run_d        = run_q;
    if (grant_data_d) begin
      if (!inst_req)
        run_d = '0;
      else if (run_q != RUN_MAX)
        run_d = run_q + 1'b1;
    end else if (grant_inst_d) begin
      run_d = '0;
    end
  end

  // Transaction FSM with registered master-side request fields.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      run_q     <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_size_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data_d) begin
            owner_q   <= 1'b1;
            run_q     <= run_d;
            m_req_q   <= 1'b1;
            m_wr_q    <= data_wr;
            m_size_q  <= data_size;
            m_addr_q  <= data_addr;
            m_wdata_q <= data_wdata;
            state_q   <= ADDR;
          end else if (grant_inst_d) begin
            owner_q   <= 1'b0;
            run_q     <= run_d;
            m_req_q   <= 1'b1;
            m_wr_q    <= 1'b0;
            m_size_q  <= 2'd2;
            m_addr_q  <= inst_addr;
            m_wdata_q <= '0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            m_req_q <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (m_data_ok)
            state_q <= IDLE;
        end
        default: begin
          m_req_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake pass-through to the owner; reset suppresses any pulse in flight.
  always_comb begin
    addr_hs      = !cpu_rst && (state_q == ADDR) && m_addr_ok;
    data_hs      = !cpu_rst && (state_q == DATA) && m_data_ok;
    inst_addr_ok = addr_hs && !owner_q;
    data_addr_ok = addr_hs &&  owner_q;
    inst_data_ok = data_hs && !owner_q;
    data_data_ok = data_hs &&  owner_q;
    inst_rdata   = inst_data_ok ? m_rdata : '0;
    data_rdata   = data_data_ok ? m_rdata : '0;
  end

  assign m_req   = m_req_q;
  assign m_wr    = m_wr_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed stimulus with the bench acting as the
// slave, a transaction-level reference model, and literal spot checks.
module tb_sram_req_arbiter;

  localparam int AW   = 32;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_addr_ok, inst_data_ok;
  logic [31:0]   inst_rdata;
  logic          data_req = 1'b0;
  logic          data_wr = 1'b0;
  logic [1:0]    data_size = '0;
  logic [AW-1:0] data_addr = '0;
  logic [31:0]   data_wdata = '0;
  logic          data_addr_ok, data_data_ok;
  logic [31:0]   data_rdata;
  logic          m_req, m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_addr_ok = 1'b0;
  logic          m_data_ok = 1'b0;
  logic [31:0]   m_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_DATA_RUN(MAXR), .ADDR_W(AW)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_size      (m_size),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_addr_ok   (m_addr_ok),
    .m_data_ok   (m_data_ok),
    .m_rdata     (m_rdata),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one outstanding transaction record ----
  bit          tx_valid    = 1'b0;
  bit          tx_owner    = 1'b0;   // 1 = data
  bit          tx_accepted = 1'b0;
  int          run_cnt     = 0;
  logic        e_wr        = 1'b0;
  logic [1:0]  e_size      = '0;
  logic [31:0] e_addr      = '0;
  logic [31:0] e_wdata     = '0;
  bit          grant_log[$];

  always @(posedge clk) begin
    if (rst) begin
      tx_valid = 0; tx_owner = 0; tx_accepted = 0; run_cnt = 0;
      e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
    end else if (!tx_valid) begin
      if (data_req && (!inst_req || run_cnt < MAXR)) begin
        tx_valid = 1; tx_owner = 1; tx_accepted = 0;
        e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
        run_cnt = inst_req ? ((run_cnt < MAXR) ? run_cnt + 1 : MAXR) : 0;
        grant_log.push_back(1'b1);
      end else if (inst_req) begin
        tx_valid = 1; tx_owner = 0; tx_accepted = 0;
        e_wr = 0; e_size = 2; e_addr = inst_addr; e_wdata = 0;
        run_cnt = 0;
        grant_log.push_back(1'b0);
      end
    end else if (!tx_accepted) begin
      if (m_addr_ok) tx_accepted = 1;
    end else if (m_data_ok) begin
      tx_valid = 0;
    end
  end

  // ---------------- per-cycle compare against the model --------------------
  logic ah, dh;
  always @(negedge clk) begin
    if (chk_en) begin
      ah = !rst && tx_valid && !tx_accepted && m_addr_ok;
      dh = !rst && tx_valid &&  tx_accepted && m_data_ok;
      chk("m_req",        m_req,        tx_valid && !tx_accepted);
      chk("busy",         busy,         tx_valid);
      chk("m_wr",         m_wr,         e_wr);
      chk("m_size",       m_size,       e_size);
      chk("m_addr",       m_addr,       e_addr);
      chk("m_wdata",      m_wdata,      e_wdata);
      chk("inst_addr_ok", inst_addr_ok, ah && !tx_owner);
      chk("data_addr_ok", data_addr_ok, ah &&  tx_owner);
      chk("inst_data_ok", inst_data_ok, dh && !tx_owner);
      chk("data_data_ok", data_data_ok, dh &&  tx_owner);
      chk("inst_rdata",   inst_rdata,   (dh && !tx_owner) ? m_rdata : 32'h0);
      chk("data_rdata",   data_rdata,   (dh &&  tx_owner) ? m_rdata : 32'h0);
    end
  end

  // ---------------- stimulus helpers (start/end at posedge + 1) ------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cycle();
    end
    chk({name, "_mreq_seen"}, seen, 1'b1);
  endtask

  // Bench-as-slave: accept after addr_delay cycles, then return rdata.
  task automatic serve(input bit which, input int addr_delay, input logic [31:0] rd, input bit drop);
    wait_mreq(which ? "serve_data" : "serve_inst");
    repeat (addr_delay) cycle();
    m_addr_ok = 1'b1;
    #1;
    chk("owner_addr_ok", which ? data_addr_ok : inst_addr_ok, 1'b1);
    chk("other_addr_ok", which ? inst_addr_ok : data_addr_ok, 1'b0);
    cycle();
    m_addr_ok = 1'b0;
    if (drop) begin
      if (which) data_req = 1'b0;
      else       inst_req = 1'b0;
    end
    m_data_ok = 1'b1;
    m_rdata   = rd;
    #1;
    chk("owner_data_ok", which ? data_data_ok : inst_data_ok, 1'b1);
    chk("owner_rdata",   which ? data_rdata   : inst_rdata,   rd);
    chk("other_data_ok", which ? inst_data_ok : data_data_ok, 1'b0);
    cycle();
    m_data_ok = 1'b0;
    m_rdata   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int base;

    // reset
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("rst_m_req",  m_req,  1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_rdata",  data_rdata | inst_rdata, 32'h0);
    rst = 1'b0;
    cycle();

    // single load
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1FC0_0010;
    cycle();
    chk("load_mreq_latency", m_req,  1'b1);
    chk("load_m_addr",       m_addr, 32'h1FC0_0010);
    chk("load_m_wr",         m_wr,   1'b0);
    serve(1'b1, 2, 32'hDEAD_BEEF, 1'b1);
    cycle();

    // simultaneous requests: data first, then inst
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
    cycle();
    chk("sim_first_wr",   m_wr,   1'b1);
    chk("sim_first_addr", m_addr, 32'h8000_1000);
    serve(1'b1, 0, 32'h0, 1'b1);
    cycle();
    chk("sim_inst_addr",  m_addr,  32'hBFC0_0100);
    chk("sim_inst_size",  m_size,  2'd2);
    chk("sim_inst_wr",    m_wr,    1'b0);
    chk("sim_inst_wdata", m_wdata, 32'h0);
    serve(1'b0, 1, 32'h0000_0024, 1'b1);
    cycle();

    // starvation bound
    base = grant_log.size();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) serve(1'b1, 0, 32'h100 + k, 1'b0);
    serve(1'b0, 0, 32'hAAAA_0000, 1'b0);
    serve(1'b1, 0, 32'h5555_0000, 1'b1);
    serve(1'b0, 0, 32'hAAAA_0001, 1'b1);
    chk("starve_log_len", grant_log.size() - base, 7);
    for (int k = 0; k < 7; k++)
      if (base + k < grant_log.size())
        chk($sformatf("starve_grant_%0d", k), grant_log[base + k], exp_seq[k]);
    cycle();

    // store with slave stall
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h8000_2003; data_wdata = 32'h0000_00A5;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("stall_m_req",   m_req,   1'b1);
      chk("stall_m_wdata", m_wdata, 32'h0000_00A5);
      chk("stall_m_size",  m_size,  2'd0);
      chk("stall_m_addr",  m_addr,  32'h8000_2003);
      chk("stall_busy",    busy,    1'b1);
      cycle();
    end
    serve(1'b1, 0, 32'h0, 1'b1);
    cycle();

    // stray m_data_ok in IDLE
    m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_data_ok", data_data_ok | inst_data_ok, 1'b0);
    chk("stray_busy",    busy, 1'b0);
    cycle();
    chk("stray_busy_after", busy,  1'b0);
    chk("stray_mreq_after", m_req, 1'b0);
    m_data_ok = 1'b0; m_rdata = '0;
    cycle();

    // reset mid-ADDR
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0040;
    cycle();
    chk("rstaddr_mreq", m_req, 1'b1);
    rst = 1'b1; m_addr_ok = 1'b1;
    #1;
    chk("rstaddr_no_addr_ok", data_addr_ok, 1'b0);
    cycle();
    rst = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    chk("rstaddr_mreq_after", m_req, 1'b0);
    chk("rstaddr_busy_after", busy,  1'b0);
    for (int k = 0; k < 3; k++) begin
      m_data_ok = 1'b1;
      #1;
      chk("rstaddr_no_data_ok", data_data_ok, 1'b0);
      cycle();
    end
    m_data_ok = 1'b0;
    cycle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory master port between the instruction-fetch requester and the memory-stage data requester (the load/store issue logic that drives data_req/data_wr/data_addr and waits on data_addr_ok/data_data_ok).
- Sits between the CPU core and the bus bridge.
- Allows one outstanding transaction at a time.
- Data side has priority, with a bounded-starvation guarantee for instruction fetch.

Parameters:
- MAX_DATA_RUN, 4: maximum consecutive data grants while inst_req is pending before instruction fetch is forced.
- ADDR_W, 32: address width.

Ports:
- cpu_clk_50M  in  1  system clock.
- cpu_rst  in  1  reset; synchronous, active-high.
- inst_req  in  1  fetch request; held high until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  load/store request; held high until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  physical address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  load data valid / store complete.
- data_rdata  out  32  load data.
- m_req  out  1  master request.
- m_wr  out  1  master write.
- m_size  out  2  master size.
- m_addr  out  ADDR_W  master address.
- m_wdata  out  32  master write data.
- m_addr_ok  in  1  slave accepted address.
- m_data_ok  in  1  slave data/response.
- m_rdata  in  32  slave read data.
- busy  out  1  transaction outstanding (state != IDLE).

Behaviour:
- FSM states: IDLE, ADDR, DATA. Owner register: 0 = inst, 1 = data.
- Reset (cpu_rst = 1 at a clock edge): state = IDLE, owner = 0, run counter = 0.
  - m_req, m_wr, m_size, m_addr, m_wdata = 0.
  - All *_addr_ok and *_data_ok = 0; inst_rdata and data_rdata = 0.
  - Applies mid-transaction: any outstanding transaction is dropped and no ok pulse is issued. The slave is reset by the same signal.
- IDLE arbitration:
  - If data_req and (not inst_req or run < MAX_DATA_RUN): grant data.
  - Else if inst_req: grant inst.
  - On a grant, latch addr/wr/size/wdata into the m_* registers (inst grant: m_wr = 0, m_size = 2, m_wdata = 0), set owner, go to ADDR. Request-to-m_req latency is exactly 1 cycle.
- Run counter:
  - Increments on a data grant while inst_req = 1, saturating at MAX_DATA_RUN.
  - Clears on any inst grant, and on a data grant while inst_req = 0.
- ADDR:
  - m_req = 1; m_* fields stay stable until m_addr_ok.
  - In the m_addr_ok cycle, the owner's *_addr_ok = 1 combinationally (same cycle); the other side's is 0.
  - Next state DATA; m_req drops the following cycle.
- DATA:
  - m_req = 0. Wait for m_data_ok.
  - In the m_data_ok cycle, the owner's *_data_ok = 1 and its *_rdata = m_rdata (combinational pass-through; rdata is 0 whenever data_ok is 0).
  - Next state IDLE. Back-to-back transactions are therefore spaced by at least one IDLE cycle.
- m_data_ok in IDLE or ADDR is ignored. A slave must not assert addr_ok and data_ok in the same cycle.
- A requester dropping req while in ADDR is illegal. The arbiter ignores it and completes the latched transaction.
- Simultaneous inst_req and data_req with run < MAX_DATA_RUN: data wins.
- Non-owner *_addr_ok and *_data_ok are always 0.
- Stores complete on data_data_ok. Loads return data on data_data_ok.

Test Plan:
- Reset mid-ADDR: data_req, cpu_rst asserted during ADDR -> next cycle m_req = 0, busy = 0, no data_addr_ok or data_data_ok pulse afterwards.
- Single load: data_req = 1, data_wr = 0, addr = 0x1FC0_0010; slave addr_ok 2 cycles later, data_ok returns 0xDEADBEEF -> m_req high 1 cycle after request, data_addr_ok pulse aligned with m_addr_ok, data_rdata = 0xDEADBEEF with data_data_ok, inst_* oks stay 0.
- Simultaneous: inst_req and data_req both rise together -> data granted first (m_wr/m_addr from data side); inst granted in the next IDLE, m_size = 2, m_wr = 0.
- Starvation bound: inst_req held high, data_req held high, MAX_DATA_RUN = 4 -> exactly 4 data grants, then an inst grant, run counter cleared.
- Store with slave stall: data_wr = 1, size = 0, wdata = 0x000000A5; m_addr_ok held low 5 cycles -> m_* fields stable all 5 cycles; completion on data_data_ok; busy high throughout.
- Stray m_data_ok asserted in IDLE -> no *_data_ok output, state stays IDLE.
